fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Fetch stage of the 5-stage pipeline: owns the PC register, issues instruction-memory requests, and loads the F/D latch.
- Consumes the next-PC value and the jump/branch flush signals produced by next-PC logic; feeds pc and the fetched instruction to decode.
- Handles variable-latency imem through a req/ack handshake, with a one-entry skid buffer for stalls and kill of in-flight requests on redirect.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP, 32'h00000000, instruction word inserted into F/D on bubble/flush

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset
pc_next  input  32  next PC from next-PC logic
stall  input  1  decode hazard stall; F/D must hold
flushJ  input  1  jump/JR/BEX redirect
flushB  input  1  taken-branch redirect
imem_ack  input  1  imem data valid this cycle for current request
imem_rdata  input  32  instruction word, valid when imem_ack
imem_req  output  1  request active
imem_addr  output  32  request address, stable while imem_req & ~imem_ack
pc  output  32  architectural fetch PC (to next-PC logic)
fd_pc  output  32  F/D latch PC
fd_ir  output  32  F/D latch instruction
fd_valid  output  1  F/D holds a real instruction

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clock, reset_n).
- Reset (reset_n=0 at edge): state=BOOT, pc=RESET_PC, imem_addr=RESET_PC, fd_pc=0, fd_ir=NOP, fd_valid=0, buffer empty, imem_req=0. Reset mid-request abandons it; a late ack after reset is ignored (BOOT has req=0).
- flush = flushJ | flushB; flush has priority over stall and ack.
- imem_addr driven from internal req_addr register, never directly from pc.
- Bubble rule: any cycle without an F/D load and without stall → fd_ir<=NOP, fd_valid<=0. With stall and no flush → F/D unchanged.
- BOOT: imem_req=0; next cycle → REQ, req_addr<=pc.
- REQ (imem_req=1):
  - flush & ack: data dropped; F/D bubble; pc<=pc_next; req_addr<=pc_next; stay REQ.
  - flush & ~ack: F/D bubble; pc<=pc_next; req_addr unchanged → KILL.
  - ~flush & ack & ~stall: fd_pc<=pc, fd_ir<=imem_rdata, fd_valid<=1; pc<=pc_next; req_addr<=pc_next; stay REQ. Back-to-back acks give 1 instruction/cycle.
  - ~flush & ack & stall: buf_ir<=imem_rdata, buf_pc<=pc → HOLD.
  - ~flush & ~ack: bubble unless stall; stay REQ.
- HOLD (imem_req=0, buffer full):
  - flush: buffer cleared; F/D bubble; pc<=pc_next; req_addr<=pc_next → REQ.
  - ~stall: F/D<=buffer (fd_valid=1); pc<=pc_next; req_addr<=pc_next → REQ.
  - stall: hold everything.
- KILL (imem_req=1, old req_addr):
  - ack: data dropped; req_addr<=pc → REQ.
  - flush (with or without ack): pc<=pc_next; if ack → REQ with req_addr<=pc_next, else stay KILL.
  - F/D bubbles unless stall.
- pc changes only on F/D load, on HOLD release, or on flush. pc_next is sampled only in those cycles.
- All PC values are plain 32-bit; no arithmetic inside this block.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0], both 0 on reset.
  - perf_fetched increments on each F/D load with fd_valid=1.
  - perf_bubbles increments on each bubble cycle.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then imem_ack held 1, stall=0, pc_next=pc+1 → imem_req=0 in cycle 1; fd_ir=mem[0],mem[1],mem[2] on consecutive cycles; fd_pc=0,1,2; fd_valid=1.
- ack latency 3 cycles → exactly 2 bubble cycles (fd_ir=NOP, fd_valid=0) between valid instructions; imem_addr stable during wait.
- stall asserted in the ack cycle for pc=5 → HOLD, imem_req=0, F/D unchanged; stall released after 2 cycles → fd_pc=5 next edge, then request for 6.
- flushB with pc_next=0x40 while request for 0x10 is outstanding → KILL; ack for 0x10 discarded (never in F/D); next request imem_addr=0x40; fd_pc=0x40 when its ack arrives.
- flushJ and stall both in HOLD with pc_next=0x80 → buffer dropped, fd_valid=0, imem_addr=0x80 next cycle.
- reset_n=0 in the middle of a KILL wait, then ack arrives → ignored; pc=RESET_PC, first fd_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// Latency: none, this is wiring only. The bus carries no combinational paths of its own.
// Backpressure: imem stretches a request by withholding imem_ack, and the fetch side holds imem_addr until then.
//
// Ports (modport master = fetch side, modport slave = memory side):
//   imem_req    fetch -> mem  a request is active this cycle
//   imem_addr   fetch -> mem  request address, stable while imem_req & ~imem_ack
//   imem_ack    mem -> fetch  imem_rdata is valid for the current request
//   imem_rdata  mem -> fetch  instruction word, meaningful only with imem_ack
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests and loads the F/D latch.
// Latency: one edge from imem_ack to F/D. Back-to-back acks deliver one instruction per cycle.
// Backpressure: decode stall holds F/D. An ack taken under stall is parked in a one-entry skid buffer.
//
// Ports:
//   clock, reset_n      rising-edge clock and synchronous active-low reset
//   imem                fetch_unit_if.master: imem_req/imem_addr out, imem_ack/imem_rdata in
//   pc_next             next PC from the next-PC logic. It is sampled only on an F/D load,
//                       on a skid-buffer release, or on a flush.
//   stall               decode hazard. F/D holds unless a flush is also present.
//   flushJ, flushB      jump/JR/BEX and taken-branch redirects. flushJ | flushB has
//                       priority over stall and ack.
//   pc                  architectural fetch PC
//   fd_pc, fd_ir        F/D latch contents
//   fd_valid            F/D holds a real instruction
//   perf_fetched        (FETCH_PERF_EN only) count of F/D loads, wraps at 2^32
//   perf_bubbles        (FETCH_PERF_EN only) count of bubble cycles, wraps at 2^32
//
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
// When the macro is undefined, the counter ports and the counters are removed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset_n,
    fetch_unit_if.master imem,
    input  logic [31:0]  pc_next,
    input  logic         stall,
    input  logic         flushJ,
    input  logic         flushB,
    output logic [31:0]  pc,
    output logic [31:0]  fd_pc,
    output logic [31:0]  fd_ir,
    output logic         fd_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_bubbles
`endif
);

    // BOOT : the cycle after reset. No request is issued yet.
    // REQ  : a request for req_addr_q (== pc_q) is outstanding.
    // HOLD : an ack arrived under stall. The word sits in the skid buffer and no request is issued.
    // KILL : a redirect happened while a request was in flight. The request stays
    //        on the bus, unchanged, until its ack arrives, and its data is dropped.
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic        req_q;
    logic [31:0] fd_pc_q;
    logic [31:0] fd_ir_q;
    logic        fd_valid_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_ir_q;
    logic        buf_vld_q;

    // Per-cycle decode of what happens to the F/D latch at the next edge.
    logic flush;
    logic ack_in_req;
    logic ack_in_kill;
    logic load_mem;
    logic load_buf;
    logic fd_load;
    logic bubble;

    always_comb begin
        flush       = flushJ | flushB;
        // An ack is only meaningful while a request is on the bus. A late ack in
        // BOOT or HOLD (req low) is ignored.
        ack_in_req  = (state_q == S_REQ)  & imem.imem_ack;
        ack_in_kill = (state_q == S_KILL) & imem.imem_ack;
        load_mem    = ack_in_req & ~flush & ~stall;
        load_buf    = (state_q == S_HOLD) & buf_vld_q & ~flush & ~stall;
        fd_load     = load_mem | load_buf;
        // A flush always bubbles F/D, even under stall. Otherwise stall freezes F/D.
        bubble      = ~fd_load & (flush | ~stall);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_q      <= 1'b0;
            fd_pc_q    <= 32'h0000_0000;
            fd_ir_q    <= NOP;
            fd_valid_q <= 1'b0;
            buf_pc_q   <= 32'h0000_0000;
            buf_ir_q   <= NOP;
            buf_vld_q  <= 1'b0;
        end else begin
            // F/D latch
            if (load_mem) begin
                fd_pc_q    <= pc_q;
                fd_ir_q    <= imem.imem_rdata;
                fd_valid_q <= 1'b1;
            end else if (load_buf) begin
                fd_pc_q    <= buf_pc_q;
                fd_ir_q    <= buf_ir_q;
                fd_valid_q <= 1'b1;
            end else if (bubble) begin
                fd_ir_q    <= NOP;
                fd_valid_q <= 1'b0;
            end

            // PC / request sequencing
            case (state_q)
                S_BOOT: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                    if (flush) begin
                        // Nothing is in flight yet, so redirect the first request directly.
                        pc_q       <= pc_next;
                        req_addr_q <= pc_next;
                    end else begin
                        req_addr_q <= pc_q;
                    end
                end

                S_REQ: begin
                    if (flush) begin
                        pc_q <= pc_next;
                        if (imem.imem_ack) begin
                            // The old request completes this cycle, so the
                            // redirected one can go out immediately.
                            req_addr_q <= pc_next;
                        end else begin
                            // The old address must stay on the bus until its ack arrives.
                            state_q <= S_KILL;
                        end
                    end else if (imem.imem_ack) begin
                        if (stall) begin
                            buf_pc_q  <= pc_q;
                            buf_ir_q  <= imem.imem_rdata;
                            buf_vld_q <= 1'b1;
                            req_q     <= 1'b0;
                            state_q   <= S_HOLD;
                        end else begin
                            pc_q       <= pc_next;
                            req_addr_q <= pc_next;
                        end
                    end
                end

                S_HOLD: begin
                    if (flush || !stall) begin
                        // On a flush the buffered word is discarded. On a release it
                        // moves into F/D through load_buf. Either way fetch resumes at pc_next.
                        buf_vld_q  <= 1'b0;
                        pc_q       <= pc_next;
                        req_addr_q <= pc_next;
                        req_q      <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end

                S_KILL: begin
                    if (flush) begin
                        pc_q <= pc_next;
                        if (imem.imem_ack) begin
                            req_addr_q <= pc_next;
                            state_q    <= S_REQ;
                        end
                    end else if (imem.imem_ack) begin
                        // The stale word is dropped. pc already holds the redirect target.
                        req_addr_q <= pc_q;
                        state_q    <= S_REQ;
                    end
                end

                default: begin
                    state_q <= S_BOOT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_bubbles_q <= 32'h0000_0000;
        end else begin
            if (fd_load) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (bubble) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

    // Unused-state check: ack_in_kill is kept for readability of the KILL decode only.
    logic unused_ok;
    assign unused_ok = ack_in_kill & ack_in_req;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = req_addr_q;
    assign pc             = pc_q;
    assign fd_pc          = fd_pc_q;
    assign fd_ir          = fd_ir_q;
    assign fd_valid       = fd_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] pc_next;
    logic        stall;
    logic        flushJ;
    logic        flushB;
    logic [31:0] pc;
    logic [31:0] fd_pc;
    logic [31:0] fd_ir;
    logic        fd_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    fetch_unit_if imem_bus();

    fetch_unit #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .imem     (imem_bus),
        .pc_next  (pc_next),
        .stall    (stall),
        .flushJ   (flushJ),
        .flushB   (flushB),
        .pc       (pc),
        .fd_pc    (fd_pc),
        .fd_ir    (fd_ir),
        .fd_valid (fd_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int wait_cnt = 0;

    // Instruction memory contents. Multiplying by an odd constant is a bijection,
    // so every address maps to a distinct, almost always non-NOP word.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    // Advance one cycle. Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // The next-PC logic computes pc+1. The memory returns the word for the current address.
    task automatic drive_seq();
        pc_next = pc + 32'd1;
        imem_bus.imem_rdata = instr_of(imem_bus.imem_addr);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall = 1'b0; flushJ = 1'b0; flushB = 1'b0; pc_next = 32'h0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Variable-latency memory: 0..3 wait cycles per request.
    task automatic resp_step();
        if (!imem_bus.imem_req) begin
            imem_bus.imem_ack = 1'b0;
            wait_cnt = $urandom_range(0, 3);
        end else if (wait_cnt == 0) begin
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = instr_of(imem_bus.imem_addr);
            wait_cnt = $urandom_range(0, 3);
        end else begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = 32'hDEAD_BEEF;
            wait_cnt--;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
        n_checks++; if (imem_bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_bus.imem_addr, RESET_PC); end
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
        n_checks++; if (fd_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fd_pc: got %h want 0", fd_pc); end
        n_checks++; if (fd_ir !== NOP) begin n_fail++; $display("FAIL reset_fd_ir: got %h want %h", fd_ir, NOP); end
        n_checks++; if (fd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fd_valid: got %b want 0", fd_valid); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL reset_perf_fetched: got %h want 0", perf_fetched); end
        n_checks++; if (perf_bubbles !== 32'h0) begin n_fail++; $display("FAIL reset_perf_bubbles: got %h want 0", perf_bubbles); end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        imem_bus.imem_ack = 1'b1;
        drive_seq();
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_boot_req: got %b want 0", imem_bus.imem_req); end
        tick();
        n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req: got %b want 1", imem_bus.imem_req); end
        n_checks++; if (fd_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_bubble: got %b want 0", fd_valid); end
        for (int k = 0; k < 4; k++) begin
            drive_seq();
            tick();
            n_checks++; if (fd_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, fd_valid); end
            n_checks++; if (fd_pc !== RESET_PC + k) begin n_fail++; $display("FAIL stream_fd_pc[%0d]: got %h want %h", k, fd_pc, RESET_PC + k); end
            n_checks++; if (fd_ir !== instr_of(RESET_PC + k)) begin n_fail++; $display("FAIL stream_fd_ir[%0d]: got %h want %h", k, fd_ir, instr_of(RESET_PC + k)); end
        end
    endtask

    task automatic test_latency();
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2; w++) begin
                imem_bus.imem_ack = 1'b0;
                drive_seq();
                tick();
                n_checks++; if (fd_valid !== 1'b0 || fd_ir !== NOP) begin n_fail++; $display("FAIL latency_bubble[%0d.%0d]: got v=%b ir=%h want v=0 ir=%h", k, w, fd_valid, fd_ir, NOP); end
                n_checks++; if (imem_bus.imem_addr !== k) begin n_fail++; $display("FAIL latency_addr_stable[%0d.%0d]: got %h want %h", k, w, imem_bus.imem_addr, k); end
            end
            imem_bus.imem_ack = 1'b1;
            drive_seq();
            tick();
            n_checks++; if (fd_valid !== 1'b1 || fd_pc !== k || fd_ir !== instr_of(k)) begin n_fail++; $display("FAIL latency_load[%0d]: got v=%b pc=%h ir=%h want v=1 pc=%h ir=%h", k, fd_valid, fd_pc, fd_ir, k, instr_of(k)); end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        tick();
        imem_bus.imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_seq();
            tick();
        end
        n_checks++; if (pc !== 32'd5) begin n_fail++; $display("FAIL hold_pre_pc: got %h want 5", pc); end
        drive_seq();
        stall = 1'b1;
        tick();
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b want 0", imem_bus.imem_req); end
        n_checks++; if (fd_pc !== 32'd4 || fd_ir !== instr_of(32'd4) || fd_valid !== 1'b1) begin n_fail++; $display("FAIL hold_fd_frozen: got pc=%h ir=%h v=%b want pc=4 ir=%h v=1", fd_pc, fd_ir, fd_valid, instr_of(32'd4)); end
        imem_bus.imem_ack = 1'b0;
        drive_seq();
        tick();
        n_checks++; if (imem_bus.imem_req !== 1'b0 || fd_pc !== 32'd4 || pc !== 32'd5) begin n_fail++; $display("FAIL hold_second_cycle: got req=%b fd_pc=%h pc=%h want req=0 fd_pc=4 pc=5", imem_bus.imem_req, fd_pc, pc); end
        stall = 1'b0;
        drive_seq();
        tick();
        n_checks++; if (fd_pc !== 32'd5 || fd_ir !== instr_of(32'd5) || fd_valid !== 1'b1) begin n_fail++; $display("FAIL hold_release_fd: got pc=%h ir=%h v=%b want pc=5 ir=%h v=1", fd_pc, fd_ir, fd_valid, instr_of(32'd5)); end
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'd6) begin n_fail++; $display("FAIL hold_release_req: got req=%b addr=%h want req=1 addr=6", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_flush_kill();
        do_reset();
        tick();
        imem_bus.imem_ack = 1'b1;
        drive_seq();
        flushB = 1'b1; pc_next = 32'h10;
        tick();
        n_checks++; if (imem_bus.imem_addr !== 32'h10 || fd_valid !== 1'b0) begin n_fail++; $display("FAIL kill_flush_ack: got addr=%h v=%b want addr=10 v=0", imem_bus.imem_addr, fd_valid); end
        flushB = 1'b0; imem_bus.imem_ack = 1'b0;
        drive_seq();
        tick();
        drive_seq();
        flushB = 1'b1; pc_next = 32'h40;
        tick();
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h10 || pc !== 32'h40) begin n_fail++; $display("FAIL kill_enter: got req=%b addr=%h pc=%h want req=1 addr=10 pc=40", imem_bus.imem_req, imem_bus.imem_addr, pc); end
        flushB = 1'b0; imem_bus.imem_ack = 1'b1;
        drive_seq();
        tick();
        n_checks++; if (fd_valid !== 1'b0 || fd_ir !== NOP) begin n_fail++; $display("FAIL kill_drop: got v=%b ir=%h want v=0 ir=%h", fd_valid, fd_ir, NOP); end
        n_checks++; if (imem_bus.imem_addr !== 32'h40 || imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL kill_new_addr: got req=%b addr=%h want req=1 addr=40", imem_bus.imem_req, imem_bus.imem_addr); end
        drive_seq();
        tick();
        n_checks++; if (fd_pc !== 32'h40 || fd_ir !== instr_of(32'h40) || fd_valid !== 1'b1) begin n_fail++; $display("FAIL kill_target_load: got pc=%h ir=%h v=%b want pc=40 ir=%h v=1", fd_pc, fd_ir, fd_valid, instr_of(32'h40)); end
    endtask

    task automatic test_hold_flush();
        do_reset();
        tick();
        imem_bus.imem_ack = 1'b1;
        drive_seq();
        tick();
        drive_seq();
        stall = 1'b1;
        tick();
        n_checks++; if (imem_bus.imem_req !== 1'b0 || fd_pc !== 32'h0) begin n_fail++; $display("FAIL hflush_hold: got req=%b fd_pc=%h want req=0 fd_pc=0", imem_bus.imem_req, fd_pc); end
        imem_bus.imem_ack = 1'b0;
        drive_seq();
        flushJ = 1'b1; pc_next = 32'h80;
        tick();
        n_checks++; if (fd_valid !== 1'b0 || fd_ir !== NOP) begin n_fail++; $display("FAIL hflush_bubble: got v=%b ir=%h want v=0 ir=%h", fd_valid, fd_ir, NOP); end
        n_checks++; if (imem_bus.imem_addr !== 32'h80 || imem_bus.imem_req !== 1'b1 || pc !== 32'h80) begin n_fail++; $display("FAIL hflush_redirect: got req=%b addr=%h pc=%h want req=1 addr=80 pc=80", imem_bus.imem_req, imem_bus.imem_addr, pc); end
        flushJ = 1'b0; stall = 1'b0; imem_bus.imem_ack = 1'b1;
        drive_seq();
        tick();
        n_checks++; if (fd_pc !== 32'h80 || fd_valid !== 1'b1 || fd_ir !== instr_of(32'h80)) begin n_fail++; $display("FAIL hflush_target_load: got pc=%h ir=%h v=%b want pc=80 ir=%h v=1", fd_pc, fd_ir, fd_valid, instr_of(32'h80)); end
    endtask

    task automatic test_reset_in_kill();
        do_reset();
        tick();
        imem_bus.imem_ack = 1'b0;
        drive_seq();
        flushB = 1'b1; pc_next = 32'h20;
        tick();
        n_checks++; if (pc !== 32'h20 || imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rkill_enter: got pc=%h req=%b want pc=20 req=1", pc, imem_bus.imem_req); end
        flushB = 1'b0; reset_n = 1'b0;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = instr_of(32'h0);
        tick();
        n_checks++; if (pc !== RESET_PC || imem_bus.imem_req !== 1'b0 || fd_valid !== 1'b0) begin n_fail++; $display("FAIL rkill_reset: got pc=%h req=%b v=%b want pc=%h req=0 v=0", pc, imem_bus.imem_req, fd_valid, RESET_PC); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (fd_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rkill_late_ack: got v=%b req=%b addr=%h want v=0 req=1 addr=%h", fd_valid, imem_bus.imem_req, imem_bus.imem_addr, RESET_PC); end
        drive_seq();
        tick();
        n_checks++; if (fd_pc !== RESET_PC || fd_valid !== 1'b1 || fd_ir !== instr_of(RESET_PC)) begin n_fail++; $display("FAIL rkill_first_fetch: got pc=%h ir=%h v=%b want pc=%h v=1", fd_pc, fd_ir, fd_valid, RESET_PC); end
    endtask

    // Random stalls, redirects and memory latency. The model only knows the
    // architectural rules: the delivered stream is sequential from the last
    // redirect target, a flush bubbles F/D, a stall freezes it, and a pending
    // request keeps its address.
    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] p_fd_pc, p_fd_ir, p_addr, target;
        logic        p_fd_valid, p_req, p_ack, fl, st;
        int          delivered;
        int unsigned m_fetched, m_bubbles;
        exp_next = RESET_PC; delivered = 0; m_fetched = 0; m_bubbles = 0;
        do_reset();
        wait_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            resp_step();
            p_fd_pc = fd_pc; p_fd_ir = fd_ir; p_fd_valid = fd_valid;
            p_req = imem_bus.imem_req; p_ack = imem_bus.imem_ack; p_addr = imem_bus.imem_addr;
            fl = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 3) == 0);
            target = $urandom;
            flushJ  = fl & ($urandom_range(0, 1) == 1);
            flushB  = fl & ~flushJ;
            stall   = st;
            pc_next = fl ? target : pc + 32'd1;
            tick();
            if (fl) begin
                n_checks++; if (fd_valid !== 1'b0) begin n_fail++; $display("FAIL rand_flush_bubble[%0d]: got v=%b want 0", i, fd_valid); end
                exp_next = target;
                m_bubbles++;
            end else if (st) begin
                n_checks++; if (fd_pc !== p_fd_pc || fd_ir !== p_fd_ir || fd_valid !== p_fd_valid) begin n_fail++; $display("FAIL rand_stall_hold[%0d]: got pc=%h ir=%h v=%b want pc=%h ir=%h v=%b", i, fd_pc, fd_ir, fd_valid, p_fd_pc, p_fd_ir, p_fd_valid); end
            end else if (fd_valid) begin
                n_checks++; if (fd_pc !== exp_next || fd_ir !== instr_of(exp_next)) begin n_fail++; $display("FAIL rand_stream[%0d]: got pc=%h ir=%h want pc=%h ir=%h", i, fd_pc, fd_ir, exp_next, instr_of(exp_next)); end
                exp_next = exp_next + 32'd1;
                delivered++;
                m_fetched++;
            end else begin
                n_checks++; if (fd_ir !== NOP) begin n_fail++; $display("FAIL rand_bubble_ir[%0d]: got %h want %h", i, fd_ir, NOP); end
                m_bubbles++;
            end
            if (p_req && !p_ack) begin
                n_checks++; if (imem_bus.imem_addr !== p_addr) begin n_fail++; $display("FAIL rand_addr_stable[%0d]: got %h want %h", i, imem_bus.imem_addr, p_addr); end
            end
        end
        n_checks++; if (delivered < 100) begin n_fail++; $display("FAIL rand_progress: got %0d deliveries want at least 100", delivered); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== m_fetched) begin n_fail++; $display("FAIL rand_perf_fetched: got %0d want %0d", perf_fetched, m_fetched); end
        n_checks++; if (perf_bubbles !== m_bubbles) begin n_fail++; $display("FAIL rand_perf_bubbles: got %0d want %0d", perf_bubbles, m_bubbles); end
`else
        if (m_fetched + m_bubbles == 0) $display("note: no F/D activity observed");
`endif
        flushJ = 1'b0; flushB = 1'b0; stall = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flushJ = 1'b0; flushB = 1'b0; pc_next = 32'h0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
        @(negedge clock);
        test_reset();
        test_stream();
        test_latency();
        test_stall_hold();
        test_flush_kill();
        test_hold_flush();
        test_reset_in_kill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
